// File: rtl/frame_pkg.sv
// Shared types and helpers for the frame receive path.
package frame_pkg;

  localparam int FRAME_BYTES_DEF = 16;
  localparam int CRC_W           = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    WAIT_CRC = 2'd2,
    DELIVER  = 2'd3
  } state_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_crc_acc.sv
// XOR check accumulator: load on first byte, fold in later bytes, compare to a check value.
module frame_crc_acc
  import frame_pkg::*;
#(
  parameter int W = CRC_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         update,
  input  logic [W-1:0] din,
  input  logic [W-1:0] chk,
  output logic         match
);

  logic [W-1:0] acc;

  always_ff @(posedge clk) begin
    if (!reset_n)    acc <= '0;
    else if (load)   acc <= din;
    else if (update) acc <= acc ^ din;
  end

  assign match = (chk == acc);

endmodule

// File: rtl/frame_receiver.sv
// Assembles FRAME_BYTES data bytes, checks the trailing XOR byte and hands the frame
// out on a valid/ready port, with saturating error and drop counters.
module frame_receiver
  import frame_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int CRC_TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               data_in,
  input  logic                     data_valid,
  input  logic [CRC_W-1:0]         crc_in,
  input  logic                     crc_valid,
  output logic [8*FRAME_BYTES-1:0] frame_out,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic                     crc_ok,
  output logic [7:0]               err_count,
  output logic [7:0]               drop_count
);

  localparam int IDX_W = $clog2(FRAME_BYTES);
  localparam int TMO_W = $clog2(CRC_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(CRC_TIMEOUT - 1);

  state_t                         state;
  logic [IDX_W-1:0]               idx;
  logic [TMO_W-1:0]               tmo;
  logic [FRAME_BYTES-1:0][7:0]    frame_q;

  logic             acc_load, acc_upd, wr_en, drop, crc_match;
  logic [IDX_W-1:0] wr_idx;

  always_comb begin
    acc_load = (state == IDLE)    && data_valid;
    acc_upd  = (state == COLLECT) && data_valid;
    wr_en    = acc_load || acc_upd;
    wr_idx   = acc_load ? '0 : idx;
    drop     = data_valid && ((state == WAIT_CRC) || (state == DELIVER));
  end

  frame_crc_acc #(.W(CRC_W)) u_acc (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (acc_load),
    .update  (acc_upd),
    .din     (data_in),
    .chk     (crc_in),
    .match   (crc_match)
  );

  always_ff @(posedge clk) begin
    if (!reset_n)   frame_q <= '0;
    else if (wr_en) frame_q[wr_idx] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      tmo       <= '0;
      crc_ok    <= 1'b0;
      err_count <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (data_valid) begin
            idx   <= IDX_W'(1);
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (data_valid) begin
            idx <= idx + IDX_W'(1);
            if (idx == LAST_IDX) begin
              state <= WAIT_CRC;
              tmo   <= '0;
            end
          end
        end
        WAIT_CRC: begin
          // A check byte on the final timeout edge still wins over the abort.
          if (crc_valid) begin
            crc_ok <= crc_match;
            if (!crc_match) err_count <= sat_inc(err_count);
            state <= DELIVER;
          end else if (tmo == TMO_MAX) begin
            err_count <= sat_inc(err_count);
            state     <= IDLE;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        DELIVER: begin
          if (frame_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)  drop_count <= 8'h00;
    else if (drop) drop_count <= sat_inc(drop_count);
  end

  assign frame_valid = (state == DELIVER);
  assign frame_out   = frame_q;

endmodule

// File: doc/frame_receiver.md
# frame_receiver

Downstream consumer of the frame generator's byte stream. Collects FRAME_BYTES data bytes, accumulates the same 8-bit XOR check value the generator produces, compares it against the transmitted CRC byte, and presents the assembled frame with a pass/fail flag on a valid/ready output handshake. It also keeps saturating counters for check errors and dropped bytes.

## Interface
- FRAME_BYTES, 16: data bytes per frame (2..256).
- CRC_TIMEOUT, 32: cycles allowed in WAIT_CRC before the frame is abandoned (≥1).

- clk  in  1  single clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- data_in  in  8  frame byte.
- data_valid  in  1  data_in is valid this cycle.
- crc_in  in  8  transmitted check byte.
- crc_valid  in  1  crc_in is valid this cycle.
- frame_out  out  8*FRAME_BYTES  assembled frame; byte 0 in bits [7:0].
- frame_valid  out  1  frame_out and crc_ok are valid.
- frame_ready  in  1  consumer accepts the frame.
- crc_ok  out  1  received crc_in equals the locally accumulated XOR.
- err_count  out  8  saturating count of CRC mismatches and timeouts.
- drop_count  out  8  saturating count of bytes discarded.

## Operation
- States: IDLE, COLLECT, WAIT_CRC, DELIVER.
- IDLE: on data_valid, store the byte at index 0, set acc = data_in, set idx = 1, and go to COLLECT. If FRAME_BYTES-1 == 0, go straight to WAIT_CRC (not legal at the 2 minimum; no special case needed).
- COLLECT: on data_valid, store the byte at idx, set acc ^= data_in, increment idx. The byte at idx = FRAME_BYTES-1 sends the FSM to WAIT_CRC and clears the timeout counter.
- WAIT_CRC:
  - On crc_valid: crc_ok <= (crc_in == acc). A mismatch increments err_count. Go to DELIVER.
  - No crc_valid for CRC_TIMEOUT consecutive cycles: increment err_count, go to IDLE, and do not deliver the frame.
- DELIVER: frame_valid = 1. On frame_valid && frame_ready, go to IDLE.
- data_valid in WAIT_CRC or DELIVER: byte discarded, drop_count increments.
- crc_valid outside WAIT_CRC: ignored, no counter effect.
- Both counters saturate at 8'hFF and never wrap.
- A frame that fails the CRC check is still delivered, with crc_ok = 0. The consumer decides what to do with it.

## Timing
- Reset values: state IDLE, frame_valid 0, crc_ok 0, frame_out 0, err_count 0, drop_count 0, acc 0, idx 0.
- reset_n low mid-frame: all partial state is discarded on that edge, and the counters clear.
- Byte acceptance: the byte is captured on the edge where data_valid is high. There is no stall input, so the upstream block may stream one byte per cycle.
- Best case, last data byte to frame_valid = 2 cycles:
  - the last byte moves the FSM to WAIT_CRC on edge N;
  - crc_valid high in cycle N+1 is sampled at edge N+1;
  - frame_valid is high from N+1 onward.
- crc_valid in the same cycle as the last data byte (still in COLLECT): ignored. The CRC must arrive at least one cycle later.
- frame_valid and frame_out stay stable until the handshake completes. frame_valid drops the cycle after the handshake.
- First byte is accepted in IDLE in the cycle right after the handshake, so there are zero dead cycles between frames.
- Timeout: the counter starts at 0 on entry to WAIT_CRC and increments every cycle. The abort happens on the edge where it reaches CRC_TIMEOUT-1 without crc_valid. crc_valid on that same edge takes priority over the abort.

## Structure
- Package frame_pkg holds:
  - the state enum (IDLE, COLLECT, WAIT_CRC, DELIVER);
  - default FRAME_BYTES;
  - CRC_W = 8;
  - the sat_inc helper for saturating counters.
- Sub-module frame_crc_acc contains the XOR accumulator with load, update and compare. It is shared with the generator-side check logic.
- The top holds the FSM, byte buffer, index and timeout counters, and both saturating counters.

## Test plan
- Clean frame: bytes 0x01..0x10 back-to-back, then crc 0x10 one cycle after the last byte -> frame_valid 2 cycles after the last byte, crc_ok = 1, frame_out[7:0] = 0x01, frame_out[127:120] = 0x10, err_count = 0.
- Bad CRC: same bytes, crc 0x11 -> frame delivered with crc_ok = 0, err_count = 1.
- Backpressure and drops: frame_ready held low for 10 cycles in DELIVER while 3 bytes arrive -> frame_out stable, drop_count = 3, handshake then returns the FSM to IDLE.
- Timeout: 16 bytes and no crc_valid for 32 cycles -> no frame_valid, err_count = 1, state IDLE. A following clean frame is delivered correctly.
- Reset mid-frame: reset_n low after 7 bytes, then a full clean frame -> the delivered frame contains only the new bytes, and the counters are 0.
- Saturation and simultaneity:
  - 260 mismatched frames -> err_count = 0xFF;
  - crc_valid together with the last byte, and no later crc_valid -> that crc is ignored and a timeout follows.
